// File: rtl/iic_slave_regs_pkg.sv
// Shared definitions for the I2C target register endpoint.
//   state_t           : protocol state of the target FSM
//   BIT_ACK/BIT_NACK  : SDA level of an acknowledge / not-acknowledge
//   BIT_WRITE/BIT_READ: value of the R/W bit in the address byte
//   DEFAULT_SLAVE_ADDR: bus address used when the top is not overridden
package iic_slave_regs_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RD_MACK,
    ST_IGNORE
  } state_t;

  localparam logic       BIT_ACK            = 1'b0;
  localparam logic       BIT_NACK           = 1'b1;
  localparam logic       BIT_WRITE          = 1'b0;
  localparam logic       BIT_READ           = 1'b1;
  localparam logic [6:0] DEFAULT_SLAVE_ADDR = 7'b1001100;

  // Append one received bit to a byte being shifted in MSB first.
  function automatic logic [7:0] shift_in(input logic [7:0] cur, input logic b);
    return {cur[6:0], b};
  endfunction

endpackage

// File: rtl/iic_bus_sync.sv
// Synchronizes the asynchronous SCL/SDA pins into the Clk domain and
// decodes bus events from one compare register behind the synchronizers.
// Ports:
//   Clk, Reset           : system clock, synchronous active-high reset
//   SCL_in, SDA_in       : raw bus pins
//   scl_rise, scl_fall   : one-cycle SCL edge events
//   start_det, stop_det  : one-cycle START / STOP events (SDA edge while SCL high)
//   sda_s                : synchronized SDA level, used for bit sampling
module iic_bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic Clk,
  input  logic Reset,
  input  logic SCL_in,
  input  logic SDA_in,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_s
);

  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic                   scl_s;
  logic                   scl_d;
  logic                   sda_d;

  assign scl_s = scl_sync[SYNC_STAGES-1];
  assign sda_s = sda_sync[SYNC_STAGES-1];

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbour, which is what makes the
  // synchronizer chain shift by exactly one stage per clock.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      // Reset to the idle bus level so leaving reset never fakes an edge.
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], SCL_in};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], SDA_in};
      scl_d    <= scl_s;
      sda_d    <= sda_s;
    end
  end

  assign scl_rise  =  scl_s & ~scl_d;
  assign scl_fall  = ~scl_s &  scl_d;
  // SCL must be high on both sides of the SDA edge, so a data change
  // that coincides with an SCL fall is never mistaken for START/STOP.
  assign start_det =  scl_s &  scl_d &  sda_d & ~sda_s;
  assign stop_det  =  scl_s &  scl_d & ~sda_d &  sda_s;

endmodule

// File: rtl/iic_slave_regs.sv
// I2C target endpoint in front of an external 256x8 register file.
// A write transfer is {address+W, pointer, data...}; each data byte is
// written at the pointer, which then post-increments. A read transfer
// {address+R} streams bytes from the pointer until the master NACKs.
// Ports:
//   Clk, Reset : system clock, synchronous active-high reset
//   SCL_in     : bus SCL pin (asynchronous)
//   SDA_in     : bus SDA pin (asynchronous)
//   SDA_oe     : 1 = pull SDA low (open drain), 0 = release
//   Reg_we     : one-cycle write strobe with Reg_addr / Reg_wdata
//   Reg_addr   : register pointer for the access
//   Reg_wdata  : write data
//   Reg_re     : one-cycle read request, Reg_rdata valid on the next Clk
//   Reg_rdata  : read data from the register file
//   Busy       : high while this target owns the current transfer
module iic_slave_regs
  import iic_slave_regs_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR  = DEFAULT_SLAVE_ADDR,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       SCL_in,
  input  logic       SDA_in,
  output logic       SDA_oe,
  output logic       Reg_we,
  output logic [7:0] Reg_addr,
  output logic [7:0] Reg_wdata,
  output logic       Reg_re,
  input  logic [7:0] Reg_rdata,
  output logic       Busy
);

  logic scl_rise, scl_fall, start_det, stop_det, sda_s;

  iic_bus_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_bus_sync (
    .Clk      (Clk),
    .Reset    (Reset),
    .SCL_in   (SCL_in),
    .SDA_in   (SDA_in),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start_det(start_det),
    .stop_det (stop_det),
    .sda_s    (sda_s)
  );

  state_t     state_q, state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] tx_q, tx_d;
  logic [7:0] ptr_q, ptr_d;
  logic       rw_q, rw_d;
  logic       sda_oe_q, sda_oe_d;
  logic       busy_q, busy_d;
  logic       reg_we_q, reg_we_d;
  logic       reg_re_q, reg_re_d;
  logic [7:0] reg_addr_q, reg_addr_d;
  logic [7:0] reg_wdata_q, reg_wdata_d;
  logic       load_q, load_d;
  logic [7:0] byte_in;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      tx_q        <= '0;
      ptr_q       <= '0;
      rw_q        <= BIT_WRITE;
      sda_oe_q    <= 1'b0;
      busy_q      <= 1'b0;
      reg_we_q    <= 1'b0;
      reg_re_q    <= 1'b0;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
      load_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      tx_q        <= tx_d;
      ptr_q       <= ptr_d;
      rw_q        <= rw_d;
      sda_oe_q    <= sda_oe_d;
      busy_q      <= busy_d;
      reg_we_q    <= reg_we_d;
      reg_re_q    <= reg_re_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      load_q      <= load_d;
    end
  end

  assign byte_in = shift_in(shift_q, sda_s);

  // NOTE: every signal written here gets a default first; a path that
  // leaves one unassigned would infer a latch instead of a mux.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    tx_d        = tx_q;
    ptr_d       = ptr_q;
    rw_d        = rw_q;
    sda_oe_d    = sda_oe_q;
    busy_d      = busy_q;
    reg_we_d    = 1'b0;
    reg_re_d    = 1'b0;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    // Capture read data one Clk after the Reg_re pulse; the next SCL fall
    // is at least a full SCL-high phase away, so tx is ready in time.
    load_d      = reg_re_q;
    if (load_q) begin
      tx_d = Reg_rdata;
    end

    if (start_det) begin
      state_d   = ST_ADDR;
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
    end else if (stop_det) begin
      state_d   = ST_IDLE;
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
    end else begin
      case (state_q)
        ST_ADDR: begin
          if (scl_rise) begin
            shift_d   = byte_in;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              bit_cnt_d = '0;
              if (byte_in[7:1] == SLAVE_ADDR) begin
                state_d = ST_ADDR_ACK;
                busy_d  = 1'b1;
                rw_d    = byte_in[0];
                if (byte_in[0] == BIT_READ) begin
                  reg_re_d   = 1'b1;
                  reg_addr_d = ptr_q;
                end
              end else begin
                state_d = ST_IGNORE;
              end
            end
          end
        end

        ST_PTR, ST_WDATA: begin
          if (scl_rise) begin
            shift_d   = byte_in;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              bit_cnt_d = '0;
              if (state_q == ST_PTR) begin
                ptr_d   = byte_in;
                state_d = ST_PTR_ACK;
              end else begin
                reg_we_d    = 1'b1;
                reg_addr_d  = ptr_q;
                reg_wdata_d = byte_in;
                ptr_d       = ptr_q + 8'd1;
                state_d     = ST_WDATA_ACK;
              end
            end
          end
        end

        // ACK slots: bit_cnt is reused as the slot phase. The first fall
        // after the 8th rise pulls SDA low, the second one ends the slot.
        ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: begin
          if (scl_fall) begin
            if (bit_cnt_q == 4'd0) begin
              sda_oe_d  = 1'b1;
              bit_cnt_d = 4'd1;
            end else begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = '0;
              if (state_q == ST_ADDR_ACK && rw_q == BIT_READ) begin
                // The ACK-ending fall already carries the first read bit.
                sda_oe_d  = ~tx_q[7];
                tx_d      = {tx_q[6:0], 1'b0};
                bit_cnt_d = 4'd1;
                state_d   = ST_RDATA;
              end else if (state_q == ST_ADDR_ACK) begin
                state_d = ST_PTR;
              end else begin
                state_d = ST_WDATA;
              end
            end
          end
        end

        // bit_cnt counts bits already put on the bus for this byte.
        ST_RDATA: begin
          if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = '0;
              state_d   = ST_RD_MACK;
            end else begin
              sda_oe_d  = ~tx_q[7];
              tx_d      = {tx_q[6:0], 1'b0};
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end
        end

        ST_RD_MACK: begin
          if (scl_rise) begin
            if (sda_s == BIT_ACK) begin
              ptr_d      = ptr_q + 8'd1;
              reg_re_d   = 1'b1;
              reg_addr_d = ptr_q + 8'd1;
              bit_cnt_d  = '0;
              state_d    = ST_RDATA;
            end else begin
              sda_oe_d = 1'b0;
              busy_d   = 1'b0;
              state_d  = ST_IGNORE;
            end
          end
        end

        default: begin
          // ST_IDLE and ST_IGNORE only leave on START/STOP.
        end
      endcase
    end
  end

  assign SDA_oe    = sda_oe_q;
  assign Reg_we    = reg_we_q;
  assign Reg_re    = reg_re_q;
  assign Reg_addr  = reg_addr_q;
  assign Reg_wdata = reg_wdata_q;
  assign Busy      = busy_q;

endmodule
